sos_measure_scheduler: RTL and testbench

Periodic measurement controller for the speed-of-sound distance calculator. Schedules calibration runs, owns the calculator's trigger and a dedicated calculator reset, and arbitrates the speaker between program audio and the calibration impulse with muted guard intervals. It also recovers from hung measurements and publishes a running average of the last `NUM_AVG` accepted delays to the downstream distance/compensation logic.

---
 rtl/sos_pkg.sv | 23 ++
 rtl/delay_averager.sv | 61 ++++++
 rtl/sos_measure_scheduler.sv | 179 +++++++++++++++++
 tb/tb_sos_measure_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sos_pkg.sv
// Shared types and widths for the speed-of-sound measurement path.
// The distance calculator imports the same width constants so the delay
// and sample buses stay consistent across blocks.
package sos_pkg;

  localparam int SOS_DELAY_W = 12;
  localparam int SOS_AMP_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PERIOD,
    ST_GUARD_PRE,
    ST_TRIGGER,
    ST_MEASURING,
    ST_GUARD_POST
  } sched_state_t;

  // The speaker belongs to the calibration run in these states.
  function automatic logic is_calibrating(input sched_state_t s);
    return (s inside {ST_GUARD_PRE, ST_TRIGGER, ST_MEASURING, ST_GUARD_POST});
  endfunction

endpackage

// File: rtl/delay_averager.sv
// Running average of the last NUM_AVG measured delays.
// Ports:
//   clk_in, rst_in      clock, async active-high reset
//   push_in             one-cycle strobe: accept value_in
//   value_in            delay sample to accumulate
//   avg_out             sum >> log2(NUM_AVG), truncating, registered on push
//   avg_valid_out       high once NUM_AVG samples have been pushed
module delay_averager #(
  parameter int NUM_AVG     = 4,
  parameter int SOS_DELAY_W = 12
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push_in,
  input  logic [SOS_DELAY_W-1:0] value_in,
  output logic [SOS_DELAY_W-1:0] avg_out,
  output logic                   avg_valid_out
);

  // NUM_AVG is a power of two, so the pointer wraps by overflow.
  localparam int SHIFT  = $clog2(NUM_AVG);
  localparam int SUM_W  = SOS_DELAY_W + SHIFT;
  localparam int FILL_W = $clog2(NUM_AVG + 1);

  logic [SOS_DELAY_W-1:0] entry_q [NUM_AVG];
  logic [SHIFT-1:0]       wr_ptr_q;
  logic [FILL_W-1:0]      fill_q;
  logic [SUM_W-1:0]       sum_q;
  logic [SUM_W-1:0]       sum_next;

  // Entries start at zero, so subtracting the "oldest" during the fill
  // phase is harmless and the sum never underflows.
  always_comb begin
    sum_next = sum_q - SUM_W'(entry_q[wr_ptr_q]) + SUM_W'(value_in);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_AVG; i++) begin
        entry_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      sum_q         <= '0;
      avg_out       <= '0;
      avg_valid_out <= 1'b0;
    end else if (push_in) begin
      entry_q[wr_ptr_q] <= value_in;
      wr_ptr_q          <= wr_ptr_q + SHIFT'(1);
      sum_q             <= sum_next;
      avg_out           <= SOS_DELAY_W'(sum_next >> SHIFT);
      if (fill_q != FILL_W'(NUM_AVG)) begin
        fill_q <= fill_q + FILL_W'(1);
      end
      if (fill_q == FILL_W'(NUM_AVG - 1)) begin
        avg_valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sos_measure_scheduler.sv
// Periodic measurement scheduler for the speed-of-sound calculator.
// Triggers calibration runs, mutes the speaker around them, recovers hung
// measurements with a calculator reset and averages accepted delays.
//
// state          | meaning
// ---------------+------------------------------------------------------
// ST_IDLE        | disabled; speaker plays audio, tick counter cleared
// ST_WAIT_PERIOD | counting PERIOD_STEPS ticks to the next run
// ST_GUARD_PRE   | speaker muted GUARD_STEPS ticks before the impulse
// ST_TRIGGER     | one clk; meas_trigger_out high
// ST_MEASURING   | speaker carries cal_amp_in; wait for valid edge/timeout
// ST_GUARD_POST  | speaker muted GUARD_STEPS ticks after the run
//
// Ports:
//   clk_in, rst_in           clock, async active-high reset
//   step_in                  24 kHz sample strobe; all timers count it
//   enable_in, force_in      scheduling enable level, immediate-run request
//   audio_in, cal_amp_in     program audio, calculator impulse
//   meas_delay_in/valid_in   calculator result and its valid level
//   meas_trigger_out         one-clk trigger to the calculator
//   calc_rst_out             one-clk calculator reset on timeout
//   amp_out                  speaker sample, updated on step_in
//   calibrating_out          run in progress (1 clk behind the state)
//   delay_avg_out/valid_out  averaged delay
//   timeout_count_out        saturating count of aborted runs
module sos_measure_scheduler
  import sos_pkg::*;
#(
  parameter int PERIOD_STEPS  = 24000,
  parameter int GUARD_STEPS   = 240,
  parameter int TIMEOUT_STEPS = 4096,
  parameter int NUM_AVG       = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        step_in,
  input  logic                        enable_in,
  input  logic                        force_in,
  input  logic signed [SOS_AMP_W-1:0] audio_in,
  input  logic signed [SOS_AMP_W-1:0] cal_amp_in,
  input  logic [SOS_DELAY_W-1:0]      meas_delay_in,
  input  logic                        meas_valid_in,
  output logic                        meas_trigger_out,
  output logic                        calc_rst_out,
  output logic signed [SOS_AMP_W-1:0] amp_out,
  output logic                        calibrating_out,
  output logic [SOS_DELAY_W-1:0]      delay_avg_out,
  output logic                        delay_avg_valid_out,
  output logic [7:0]                  timeout_count_out
);

  localparam int CNT_MAX =
    (PERIOD_STEPS > GUARD_STEPS)
      ? ((PERIOD_STEPS > TIMEOUT_STEPS) ? PERIOD_STEPS : TIMEOUT_STEPS)
      : ((GUARD_STEPS > TIMEOUT_STEPS) ? GUARD_STEPS : TIMEOUT_STEPS);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  sched_state_t             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     valid_q;
  logic                     valid_rise;
  logic                     tick_done;
  logic                     meas_done;
  logic                     meas_timeout;
  logic                     push_q;
  logic [SOS_DELAY_W-1:0]   delay_q;

  // The counter holds remaining ticks. A zero load (length 0) finishes on
  // the first clk; otherwise the step that takes it from 1 ends the state.
  assign tick_done  = (cnt_q == '0) || (step_in && (cnt_q == CNT_W'(1)));
  assign valid_rise = meas_valid_in && !valid_q;

  always_comb begin
    state_d      = state_q;
    meas_done    = 1'b0;
    meas_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_in || force_in) state_d = ST_GUARD_PRE;
      end
      ST_WAIT_PERIOD: begin
        if (!enable_in)                  state_d = ST_IDLE;
        else if (force_in || tick_done)  state_d = ST_GUARD_PRE;
      end
      ST_GUARD_PRE: begin
        if (tick_done) state_d = ST_TRIGGER;
      end
      ST_TRIGGER: begin
        state_d = ST_MEASURING;
      end
      ST_MEASURING: begin
        // A result arriving on the final timeout tick still counts.
        if (valid_rise) begin
          meas_done = 1'b1;
          state_d   = ST_GUARD_POST;
        end else if (tick_done) begin
          meas_timeout = 1'b1;
          state_d      = ST_GUARD_POST;
        end
      end
      ST_GUARD_POST: begin
        if (tick_done) state_d = enable_in ? ST_WAIT_PERIOD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reload on every state change so each state sees its full length.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_WAIT_PERIOD: cnt_d = CNT_W'(PERIOD_STEPS);
        ST_GUARD_PRE:   cnt_d = CNT_W'(GUARD_STEPS);
        ST_MEASURING:   cnt_d = CNT_W'(TIMEOUT_STEPS);
        ST_GUARD_POST:  cnt_d = CNT_W'(GUARD_STEPS);
        default:        cnt_d = '0;
      endcase
    end else if (step_in && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q           <= 1'b0;
      push_q            <= 1'b0;
      delay_q           <= '0;
      meas_trigger_out  <= 1'b0;
      calc_rst_out      <= 1'b0;
      calibrating_out   <= 1'b0;
      amp_out           <= '0;
      timeout_count_out <= '0;
    end else begin
      // valid_q tracks the level continuously, so a level still high from
      // the previous run never looks like an edge inside MEASURING.
      valid_q          <= meas_valid_in;
      push_q           <= meas_done;
      if (meas_done) delay_q <= meas_delay_in;
      // Decoding the next state makes the pulse coincide with ST_TRIGGER.
      meas_trigger_out <= (state_d == ST_TRIGGER);
      calc_rst_out     <= meas_timeout;
      calibrating_out  <= is_calibrating(state_q);
      if (meas_timeout && (timeout_count_out != 8'hFF)) begin
        timeout_count_out <= timeout_count_out + 8'd1;
      end
      if (step_in) begin
        case (state_q)
          ST_IDLE, ST_WAIT_PERIOD: amp_out <= audio_in;
          ST_MEASURING:            amp_out <= cal_amp_in;
          default:                 amp_out <= '0;
        endcase
      end
    end
  end

  delay_averager #(
    .NUM_AVG     (NUM_AVG),
    .SOS_DELAY_W (SOS_DELAY_W)
  ) u_averager (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .push_in       (push_q),
    .value_in      (delay_q),
    .avg_out       (delay_avg_out),
    .avg_valid_out (delay_avg_valid_out)
  );

endmodule

// File: tb/tb_sos_measure_scheduler.sv
// Directed bench for sos_measure_scheduler: a table of calibration runs
// with hand-computed averages, plus sequences for timeout, held-high
// valid, edge-on-final-tick, force, enable drop and async reset.
module tb_sos_measure_scheduler;

  localparam int PERIOD  = 100;
  localparam int GUARD   = 4;
  localparam int TIMEOUT = 100;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               step_in;
  logic               enable_in;
  logic               force_in;
  logic signed [15:0] audio_in;
  logic signed [15:0] cal_amp_in;
  logic [11:0]        meas_delay_in;
  logic               meas_valid_in;
  logic               meas_trigger_out;
  logic               calc_rst_out;
  logic signed [15:0] amp_out;
  logic               calibrating_out;
  logic [11:0]        delay_avg_out;
  logic               delay_avg_valid_out;
  logic [7:0]         timeout_count_out;

  sos_measure_scheduler #(
    .PERIOD_STEPS  (PERIOD),
    .GUARD_STEPS   (GUARD),
    .TIMEOUT_STEPS (TIMEOUT),
    .NUM_AVG       (4)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .step_in             (step_in),
    .enable_in           (enable_in),
    .force_in            (force_in),
    .audio_in            (audio_in),
    .cal_amp_in          (cal_amp_in),
    .meas_delay_in       (meas_delay_in),
    .meas_valid_in       (meas_valid_in),
    .meas_trigger_out    (meas_trigger_out),
    .calc_rst_out        (calc_rst_out),
    .amp_out             (amp_out),
    .calibrating_out     (calibrating_out),
    .delay_avg_out       (delay_avg_out),
    .delay_avg_valid_out (delay_avg_valid_out),
    .timeout_count_out   (timeout_count_out)
  );

  always #5 clk_in = ~clk_in;

  // One-clk step strobe every 4 clks, changed on the falling edge.
  initial begin
    step_in = 1'b0;
    forever begin
      repeat (3) @(negedge clk_in);
      step_in = 1'b1;
      @(negedge clk_in);
      step_in = 1'b0;
    end
  end

  int tick_cnt = 0;
  bit step_d = 1'b0;
  always @(posedge clk_in) begin
    if (step_in) tick_cnt <= tick_cnt + 1;
    step_d <= step_in;
  end

  // Pulse-width counters and lengths of muted stretches of amp_out.
  int trig_cycles = 0;
  int crst_cycles = 0;
  int zrun = 0;
  int zq[$];
  always @(negedge clk_in) begin
    #2;
    if (meas_trigger_out) trig_cycles++;
    if (calc_rst_out) crst_cycles++;
    if (step_d) begin
      if (amp_out == 16'sd0) zrun++;
      else begin
        if (zrun > 0) zq.push_back(zrun);
        zrun = 0;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_clk();
    @(negedge clk_in);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_cnt + n;
    while (tick_cnt < target) next_clk();
  endtask

  task automatic pulse_force();
    force_in = 1'b1;
    next_clk();
    force_in = 1'b0;
  endtask

  task automatic wait_trigger(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      next_clk();
      if (meas_trigger_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Raise valid now; check the average one clk later (unchanged) and two
  // clks later (updated).
  task automatic respond(input int exp_prev_avg, input int exp_prev_vld,
                         input int exp_avg, input int exp_vld, input string tag);
    meas_valid_in = 1'b1;
    next_clk();
    check({tag, "_avg_1clk"}, int'(delay_avg_out), exp_prev_avg);
    check({tag, "_vld_1clk"}, int'(delay_avg_valid_out), exp_prev_vld);
    next_clk();
    check({tag, "_avg_2clk"}, int'(delay_avg_out), exp_avg);
    check({tag, "_vld_2clk"}, int'(delay_avg_valid_out), exp_vld);
  endtask

  typedef struct {
    int delay;
    int resp_tick;
    int exp_avg;
    int exp_valid;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    int t0;
    int t_edge;
    int prev_avg;
    int prev_vld;
    int crst_before;
    int trig_before;

    vecs[0] = '{100, 10, 25, 0};
    vecs[1] = '{102, 20, 50, 0};
    vecs[2] = '{104, 30, 76, 0};
    vecs[3] = '{106, 40, 103, 1};
    vecs[4] = '{110, 50, 105, 1};

    rst_in        = 1'b1;
    enable_in     = 1'b0;
    force_in      = 1'b0;
    audio_in      = 16'sh1234;
    cal_amp_in    = 16'sh0ABC;
    meas_delay_in = '0;
    meas_valid_in = 1'b0;
    t_edge        = 0;
    repeat (20) next_clk();

    check("rst_trigger", int'(meas_trigger_out), 0);
    check("rst_calc_rst", int'(calc_rst_out), 0);
    check("rst_amp", int'(amp_out), 0);
    check("rst_calibrating", int'(calibrating_out), 0);
    check("rst_avg", int'(delay_avg_out), 0);
    check("rst_avg_valid", int'(delay_avg_valid_out), 0);
    check("rst_timeouts", int'(timeout_count_out), 0);

    rst_in = 1'b0;
    wait_ticks(2);
    check("idle_amp_audio", int'(amp_out), 16'sh1234);
    check("idle_calibrating", int'(calibrating_out), 0);

    prev_avg = 0;
    prev_vld = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) enable_in = 1'b1;
      if (i == 2) begin
        check("pre_force_calibrating", int'(calibrating_out), 0);
        pulse_force();
        check("force_cal_after_1clk", int'(calibrating_out), 0);
        next_clk();
        check("force_cal_after_2clk", int'(calibrating_out), 1);
      end else if (i >= 3) begin
        pulse_force();
      end
      wait_trigger(2000, ok);
      check("run_trigger_seen", int'(ok), 1);
      if (i == 1) check("natural_period_ticks", tick_cnt - t_edge, GUARD + PERIOD + GUARD);
      meas_delay_in = 12'(vecs[i].delay);
      wait_ticks(5);
      if (i == 2) pulse_force();
      wait_ticks(vecs[i].resp_tick - 5);
      check("meas_amp_cal", int'(amp_out), 16'sh0ABC);
      check("meas_calibrating", int'(calibrating_out), 1);
      t_edge = tick_cnt;
      respond(prev_avg, prev_vld, vecs[i].exp_avg, vecs[i].exp_valid, "table");
      prev_avg = vecs[i].exp_avg;
      prev_vld = vecs[i].exp_valid;
      wait_ticks(2);
      meas_valid_in = 1'b0;
      wait_ticks(4);
      check("post_run_calibrating", int'(calibrating_out), 0);
      check("post_run_amp_audio", int'(amp_out), 16'sh1234);
      check("trigger_cycles", trig_cycles, i + 1);
    end

    check("muted_runs_recorded", (zq.size() >= 11) ? 1 : 0, 1);
    for (int k = 1; k <= 10 && k < zq.size(); k++) begin
      check("guard_muted_ticks", zq[k], GUARD);
    end

    // Calculator never answers.
    pulse_force();
    wait_trigger(2000, ok);
    check("to_trigger_seen", int'(ok), 1);
    t0 = tick_cnt;
    seen = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      next_clk();
      if (calc_rst_out) seen = 1'b1;
    end
    check("to_calc_rst_seen", int'(seen), 1);
    check("to_ticks", tick_cnt - t0, TIMEOUT);
    next_clk();
    next_clk();
    check("to_calc_rst_cycles", crst_cycles, 1);
    check("to_count", int'(timeout_count_out), 1);
    check("to_avg_unchanged", int'(delay_avg_out), 105);
    wait_ticks(6);
    check("to_post_calibrating", int'(calibrating_out), 0);

    // Valid level high through TRIGGER, falls, then rises at tick 80.
    meas_valid_in = 1'b1;
    meas_delay_in = 12'd999;
    wait_ticks(2);
    pulse_force();
    wait_trigger(2000, ok);
    check("hh_trigger_seen", int'(ok), 1);
    wait_ticks(3);
    meas_valid_in = 1'b0;
    wait_ticks(76);
    check("hh_still_measuring", int'(calibrating_out), 1);
    wait_ticks(1);
    meas_delay_in = 12'd120;
    respond(105, 1, 110, 1, "held_high");
    wait_ticks(2);
    meas_valid_in = 1'b0;
    wait_ticks(6);

    // Valid rises on the same clk as the final timeout tick.
    meas_delay_in = 12'd130;
    pulse_force();
    wait_trigger(2000, ok);
    check("ft_trigger_seen", int'(ok), 1);
    wait_ticks(TIMEOUT - 1);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      next_clk();
      if (step_in) seen = 1'b1;
    end
    respond(110, 1, 116, 1, "final_tick");
    check("ft_timeouts_unchanged", int'(timeout_count_out), 1);
    check("ft_no_calc_rst", crst_cycles, 1);
    wait_ticks(2);
    meas_valid_in = 1'b0;
    wait_ticks(6);

    // Enable dropped mid-run: the run completes, then the block idles.
    pulse_force();
    wait_trigger(2000, ok);
    check("en_trigger_seen", int'(ok), 1);
    enable_in = 1'b0;
    audio_in = 16'sh7ABC;
    meas_delay_in = 12'd140;
    wait_ticks(10);
    check("en_still_measuring", int'(calibrating_out), 1);
    respond(116, 1, 125, 1, "enable_drop");
    wait_ticks(2);
    meas_valid_in = 1'b0;
    wait_ticks(6);
    check("en_calibrating_off", int'(calibrating_out), 0);
    check("en_amp_audio", int'(amp_out), 16'sh7ABC);
    trig_before = trig_cycles;
    wait_ticks(PERIOD + 20);
    check("en_no_new_trigger", trig_cycles, trig_before);

    // Async reset in the middle of MEASURING.
    enable_in = 1'b1;
    wait_trigger(2000, ok);
    check("rs_trigger_seen", int'(ok), 1);
    wait_ticks(5);
    crst_before = crst_cycles;
    rst_in = 1'b1;
    #1;
    check("rs_trigger", int'(meas_trigger_out), 0);
    check("rs_calc_rst", int'(calc_rst_out), 0);
    check("rs_amp", int'(amp_out), 0);
    check("rs_calibrating", int'(calibrating_out), 0);
    check("rs_avg", int'(delay_avg_out), 0);
    check("rs_avg_valid", int'(delay_avg_valid_out), 0);
    check("rs_timeouts", int'(timeout_count_out), 0);
    enable_in = 1'b0;
    repeat (3) next_clk();
    check("rs_no_calc_rst_pulse", crst_cycles, crst_before);
    rst_in = 1'b0;
    repeat (2) next_clk();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
